// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter sequencer: parameter
// defaults, the next-PC select encoding and a destination alignment helper.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC_DEFAULT          = 4;
  localparam int unsigned PC_RAS_DEPTH_DEFAULT    = 4;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_SEQ      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_RET      = 2'd3
  } pc_sel_e;

  // True when the low log2(inc) bits of addr are zero; inc is a power of two.
  function automatic logic pc_is_aligned(input logic [31:0] addr,
                                         input int unsigned inc);
    logic [31:0] mask;
    mask = inc - 32'd1;
    return (addr & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: LIFO with push, pop, full/empty status and
// sticky overflow/underflow flags. A push while full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] PushData,
  output logic [WIDTH-1:0] TopData,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_ptr;

  // wr_ptr names the next free slot; when full it also names the oldest entry,
  // so a wrapped push naturally overwrites it.
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign TopData = mem[top_ptr];
  assign Full    = (count == CNT_W'(RAS_DEPTH));
  assign Empty   = (count == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (Push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (Full) begin
        Overflow <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (Pop) begin
      if (Empty) begin
        Underflow <= 1'b1;
      end else begin
        wr_ptr <= top_ptr;
        count  <= count - CNT_W'(1);
      end
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge Clk) begin
    if (Push) begin
      mem[wr_ptr] <= PushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with stall, redirect and call/return through a circular RAS.
// Optional destination alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
  parameter int unsigned     INC          = PC_INC_DEFAULT,
  parameter int unsigned     RAS_DEPTH    = PC_RAS_DEPTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOverflow,
  output logic             RasUnderflow,
  output logic             Misaligned
);

  pc_sel_e          sel;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] dest;
  logic [WIDTH-1:0] pc_next;

  assign PCPlusInc = PCResult + WIDTH'(INC);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .Push      (ras_push),
    .Pop       (ras_pop),
    .PushData  (PCPlusInc),
    .TopData   (ras_top),
    .Full      (RasFull),
    .Empty     (RasEmpty),
    .Overflow  (RasOverflow),
    .Underflow (RasUnderflow)
  );

  // Priority: stall, return, redirect (optionally with call), sequential.
  // A return on an empty stack still pops so the stack records the underflow.
  always_comb begin
    sel      = PC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (Stall) begin
      sel = PC_HOLD;
    end else if (Ret) begin
      ras_pop = 1'b1;
      sel     = RasEmpty ? PC_SEQ : PC_RET;
    end else if (Redirect) begin
      sel      = PC_REDIRECT;
      ras_push = Call;
    end
  end

  always_comb begin
    case (sel)
      PC_HOLD:     dest = PCResult;
      PC_REDIRECT: dest = Target;
      PC_RET:      dest = ras_top;
      default:     dest = PCPlusInc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic bad_dest;

  assign bad_dest = ((sel == PC_REDIRECT) || (sel == PC_RET)) &&
                    !pc_is_aligned(32'(dest), INC);
  assign pc_next  = bad_dest ? PCPlusInc : dest;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Misaligned <= 1'b0;
    end else begin
      Misaligned <= bad_dest;
    end
  end
`else
  assign pc_next    = dest;
  assign Misaligned = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PCResult <= RESET_VECTOR;
    end else begin
      PCResult <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (INC=4, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic        call;
  logic        ret;
  logic [31:0] target;
  logic [31:0] pc_result;
  logic [31:0] pc_plus_inc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misaligned;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  pc_sequencer dut (
    .Clk          (clk),
    .Reset        (reset),
    .Stall        (stall),
    .Redirect     (redirect),
    .Call         (call),
    .Ret          (ret),
    .Target       (target),
    .PCResult     (pc_result),
    .PCPlusInc    (pc_plus_inc),
    .RasEmpty     (ras_empty),
    .RasFull      (ras_full),
    .RasOverflow  (ras_overflow),
    .RasUnderflow (ras_underflow),
    .Misaligned   (misaligned)
  );

  // clock/reset block: 20 ns period so a 10 ns offset lands mid-cycle
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic rd, input logic c,
                       input logic r, input logic [31:0] t);
    stall    = s;
    redirect = rd;
    call     = c;
    ret      = r;
    target   = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF);

    // Reset held with a pending redirect
    tick();
    tick();
    check("reset_pc", pc_result, 32'h0);
    check("reset_empty", {31'b0, ras_empty}, 32'h1);
    check("reset_full", {31'b0, ras_full}, 32'h0);
    check("reset_ovf", {31'b0, ras_overflow}, 32'h0);
    check("reset_unf", {31'b0, ras_underflow}, 32'h0);
    check("reset_mis", {31'b0, misaligned}, 32'h0);
    @(posedge clk);
    #10;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("release_pc", pc_result, 32'h0);
    tick();
    check("seq_1", pc_result, 32'h4);
    tick();
    check("seq_2", pc_result, 32'h8);

    // Stall holds against a redirect
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
    tick();
    check("redir_20", pc_result, 32'h20);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc_result, 32'h20);
    end
    stall = 1'b0;
    tick();
    check("stall_release", pc_result, 32'h100);

    // Single call and return
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
    tick();
    check("redir_40", pc_result, 32'h40);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
    tick();
    check("call_pc", pc_result, 32'h200);
    check("call_nonempty", {31'b0, ras_empty}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("callee_1", pc_result, 32'h204);
    tick();
    check("callee_2", pc_result, 32'h208);
    ret = 1'b1;
    tick();
    check("ret_pc", pc_result, 32'h44);
    check("ret_empty", {31'b0, ras_empty}, 32'h1);

    // Five nested calls into a 4-deep stack; scoreboard keeps the live entries
    exp_pc = 32'h44;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i) * 32'h100);
      if (exp_q.size() == 4) void'(exp_q.pop_front());
      exp_q.push_back(exp_pc + 32'h4);
      exp_pc = target;
      tick();
      check("nest_call_pc", pc_result, exp_pc);
    end
    check("nest_full", {31'b0, ras_full}, 32'h1);
    check("nest_ovf", {31'b0, ras_overflow}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    while (exp_q.size() > 0) begin
      exp_pc = exp_q.pop_back();
      tick();
      check("nest_ret_pc", pc_result, exp_pc);
    end
    check("drain_empty", {31'b0, ras_empty}, 32'h1);
    check("drain_unf_clear", {31'b0, ras_underflow}, 32'h0);
    tick();
    check("underflow_pc", pc_result, exp_pc + 32'h4);
    check("underflow_flag", {31'b0, ras_underflow}, 32'h1);
    check("ovf_sticky", {31'b0, ras_overflow}, 32'h1);

    // Wrap-around then asynchronous mid-cycle reset
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    tick();
    check("wrap_start", pc_result, 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus_inc, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap_pc", pc_result, 32'h0);
    tick();
    check("wrap_next", pc_result, 32'h4);
    #5;
    reset = 1'b1;
    #1;
    check("async_reset_pc", pc_result, 32'h0);
    check("async_reset_ovf", {31'b0, ras_overflow}, 32'h0);
    check("async_reset_unf", {31'b0, ras_underflow}, 32'h0);
    #3;
    reset = 1'b0;

    // Misaligned redirect
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    tick();
    check("redir_10", pc_result, 32'h10);
    target = 32'h102;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_pc", pc_result, 32'h14);
    check("misalign_pulse", {31'b0, misaligned}, 32'h1);
    tick();
    check("misalign_end", {31'b0, misaligned}, 32'h0);
    check("misalign_seq", pc_result, 32'h18);
`else
    check("unaligned_pc", pc_result, 32'h102);
    check("unaligned_flag", {31'b0, misaligned}, 32'h0);
    tick();
    check("unaligned_seq", pc_result, 32'h106);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
